// File: rtl/cu_pipe.sv
// cu_pipe: registered decode stage between fetch and execute.
// It decodes one instruction per cycle into the control bundle and holds it
// behind a valid/ready handshake. The design has one output register and one
// skid entry. It also detects illegal instructions, drains the pipe after a
// FENCE, holds off new instructions after a trap, and supports a flush.
//
// state | meaning
// ------+--------------------------------------------------------------
// RUN   | normal decode, in_ready whenever the skid entry is empty
// DRAIN | FENCE accepted, in_ready low while r_cnt counts down to 1
// TRAP  | illegal instruction accepted, in_ready low until flush
module cu_pipe #(
  parameter int XLEN         = 64,
  parameter int FENCE_CYCLES = 4,
  parameter int PC_W         = 64
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [31:0]     in_inst,
  input  logic [PC_W-1:0] in_pc,
  input  logic            flush,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [31:0]     out_inst,
  output logic [PC_W-1:0] out_pc,
  output logic [2:0]      immsel,
  output logic            regwen,
  output logic            asel,
  output logic            bsel,
  output logic [3:0]      alusel,
  output logic            aluupper,
  output logic            memrw,
  output logic [1:0]      memword,
  output logic            memsign,
  output logic [1:0]      wbsel,
  output logic            jump,
  output logic            branch,
  output logic [1:0]      brcond,
  output logic            brun,
  output logic            illegal
);

  // Bundle encodings shared with the execute stage.
  localparam logic [2:0] IMM_I     = 3'd0;
  localparam logic [2:0] IMM_S     = 3'd1;
  localparam logic [2:0] IMM_B     = 3'd2;
  localparam logic [2:0] IMM_U     = 3'd3;
  localparam logic [2:0] IMM_J     = 3'd4;
  localparam logic       REGW_UN   = 1'b0;
  localparam logic       REGW_EN   = 1'b1;
  localparam logic       ASEL_REG  = 1'b0;
  localparam logic       ASEL_PC   = 1'b1;
  localparam logic       BSEL_REG  = 1'b0;
  localparam logic       BSEL_IMM  = 1'b1;
  localparam logic       MEM_READ  = 1'b0;
  localparam logic       MEM_WRITE = 1'b1;
  localparam logic [1:0] WB_ALU    = 2'd0;
  localparam logic [1:0] WB_MEM    = 2'd1;
  localparam logic [1:0] WB_PC4    = 2'd2;
  localparam logic [3:0] ALU_ADD   = 4'b0000;
  // 1111 is never produced by a register-register op, so LUI uses it as
  // "pass operand B".
  localparam logic [3:0] ALU_COPYB = 4'b1111;

  localparam logic [4:0] OPC_LOAD    = 5'b00000;
  localparam logic [4:0] OPC_FENCE   = 5'b00011;
  localparam logic [4:0] OPC_OPIMM   = 5'b00100;
  localparam logic [4:0] OPC_AUIPC   = 5'b00101;
  localparam logic [4:0] OPC_OPIMM32 = 5'b00110;
  localparam logic [4:0] OPC_STORE   = 5'b01000;
  localparam logic [4:0] OPC_OP      = 5'b01100;
  localparam logic [4:0] OPC_LUI     = 5'b01101;
  localparam logic [4:0] OPC_OP32    = 5'b01110;
  localparam logic [4:0] OPC_BRANCH  = 5'b11000;
  localparam logic [4:0] OPC_JALR    = 5'b11001;
  localparam logic [4:0] OPC_JAL     = 5'b11011;

  localparam bit         RV32       = (XLEN == 32);
  localparam logic [7:0] FENCE_INIT = 8'(FENCE_CYCLES);

  typedef struct packed {
    logic [2:0]      immsel;
    logic            regwen;
    logic            asel;
    logic            bsel;
    logic [3:0]      alusel;
    logic            aluupper;
    logic            memrw;
    logic [1:0]      memword;
    logic            memsign;
    logic [1:0]      wbsel;
    logic            jump;
    logic            branch;
    logic [1:0]      brcond;
    logic            brun;
    logic            illegal;
    logic [31:0]     inst;
    logic [PC_W-1:0] pc;
  } bundle_t;

  typedef enum logic [1:0] {ST_RUN, ST_DRAIN, ST_TRAP} state_t;

  state_t     r_state, w_state_nxt;
  logic [7:0] r_cnt, w_cnt_nxt;
  bundle_t    r_out, w_out_nxt, r_skid, w_skid_nxt, w_dec;
  logic       r_out_valid, w_out_valid_nxt;
  logic       r_skid_valid, w_skid_valid_nxt;
  logic       r_in_ready;
  logic       w_accept, w_dec_fence, w_bad;
  logic [4:0] w_opcode;
  logic [2:0] w_f3;

  assign w_opcode = in_inst[6:2];
  assign w_f3     = in_inst[14:12];
  assign w_accept = in_valid && r_in_ready;

  // Decode the offered instruction into a bundle. Illegal and FENCE bundles
  // carry no control side effects; the raw inst fields are always passed on.
  always_comb begin
    w_dec         = '0;
    w_dec_fence   = 1'b0;
    w_bad         = (in_inst[1:0] != 2'b11);
    w_dec.inst    = in_inst;
    w_dec.pc      = in_pc;
    w_dec.memword = in_inst[13:12];
    w_dec.memsign = in_inst[14];
    w_dec.brcond  = {in_inst[14], in_inst[12]};
    w_dec.brun    = in_inst[13];
    case (w_opcode)
      OPC_LOAD: begin
        w_dec.immsel   = IMM_I;
        w_dec.regwen   = REGW_EN;
        w_dec.asel     = ASEL_REG;
        w_dec.bsel     = BSEL_IMM;
        w_dec.alusel   = ALU_ADD;
        w_dec.aluupper = 1'b1;
        w_dec.memrw    = MEM_READ;
        w_dec.wbsel    = WB_MEM;
        if (w_f3 == 3'b111) w_bad = 1'b1;
        if (RV32 && (w_f3 == 3'b011 || w_f3 == 3'b110)) w_bad = 1'b1;
      end
      OPC_STORE: begin
        w_dec.immsel   = IMM_S;
        w_dec.regwen   = REGW_UN;
        w_dec.bsel     = BSEL_IMM;
        w_dec.alusel   = ALU_ADD;
        w_dec.aluupper = 1'b1;
        w_dec.memrw    = MEM_WRITE;
        if (w_f3[2]) w_bad = 1'b1;
        if (RV32 && w_f3 == 3'b011) w_bad = 1'b1;
      end
      OPC_OPIMM, OPC_OPIMM32: begin
        w_dec.immsel   = IMM_I;
        w_dec.regwen   = REGW_EN;
        w_dec.asel     = ASEL_REG;
        w_dec.bsel     = BSEL_IMM;
        w_dec.alusel   = (w_f3 == 3'b101) ? {in_inst[30], w_f3} : {1'b0, w_f3};
        w_dec.aluupper = (w_opcode == OPC_OPIMM);
        w_dec.wbsel    = WB_ALU;
        if (RV32 && w_opcode == OPC_OPIMM32) w_bad = 1'b1;
      end
      OPC_OP, OPC_OP32: begin
        w_dec.immsel   = IMM_I;
        w_dec.regwen   = REGW_EN;
        w_dec.asel     = ASEL_REG;
        w_dec.bsel     = BSEL_REG;
        w_dec.alusel   = {in_inst[30], w_f3};
        w_dec.aluupper = (w_opcode == OPC_OP);
        w_dec.wbsel    = WB_ALU;
        if (RV32 && w_opcode == OPC_OP32) w_bad = 1'b1;
      end
      OPC_LUI: begin
        w_dec.immsel   = IMM_U;
        w_dec.regwen   = REGW_EN;
        w_dec.bsel     = BSEL_IMM;
        w_dec.alusel   = ALU_COPYB;
        w_dec.aluupper = 1'b1;
        w_dec.wbsel    = WB_ALU;
      end
      OPC_AUIPC: begin
        w_dec.immsel   = IMM_U;
        w_dec.regwen   = REGW_EN;
        w_dec.asel     = ASEL_PC;
        w_dec.bsel     = BSEL_IMM;
        w_dec.alusel   = ALU_ADD;
        w_dec.aluupper = 1'b1;
        w_dec.wbsel    = WB_ALU;
      end
      OPC_JAL: begin
        w_dec.immsel   = IMM_J;
        w_dec.regwen   = REGW_EN;
        w_dec.asel     = ASEL_PC;
        w_dec.bsel     = BSEL_IMM;
        w_dec.alusel   = ALU_ADD;
        w_dec.aluupper = 1'b1;
        w_dec.wbsel    = WB_PC4;
        w_dec.jump     = 1'b1;
      end
      OPC_JALR: begin
        w_dec.immsel   = IMM_I;
        w_dec.regwen   = REGW_EN;
        w_dec.asel     = ASEL_REG;
        w_dec.bsel     = BSEL_IMM;
        w_dec.alusel   = ALU_ADD;
        w_dec.aluupper = 1'b1;
        w_dec.wbsel    = WB_PC4;
        w_dec.jump     = 1'b1;
      end
      OPC_BRANCH: begin
        w_dec.immsel   = IMM_B;
        w_dec.regwen   = REGW_UN;
        w_dec.asel     = ASEL_PC;
        w_dec.bsel     = BSEL_IMM;
        w_dec.alusel   = ALU_ADD;
        w_dec.aluupper = 1'b1;
        w_dec.branch   = 1'b1;
        if (w_f3 == 3'b010 || w_f3 == 3'b011) w_bad = 1'b1;
      end
      OPC_FENCE: w_dec_fence = 1'b1;
      default:   w_bad = 1'b1;
    endcase
    if (w_bad) begin
      w_dec.immsel   = IMM_I;
      w_dec.regwen   = REGW_UN;
      w_dec.asel     = ASEL_REG;
      w_dec.bsel     = BSEL_REG;
      w_dec.alusel   = ALU_ADD;
      w_dec.aluupper = 1'b0;
      w_dec.memrw    = MEM_READ;
      w_dec.wbsel    = WB_ALU;
      w_dec.jump     = 1'b0;
      w_dec.branch   = 1'b0;
      w_dec.illegal  = 1'b1;
      w_dec_fence    = 1'b0;
    end
  end

  // Next state and drain counter; flush overrides everything.
  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    case (r_state)
      ST_RUN: begin
        if (w_accept && w_dec_fence) begin
          w_state_nxt = ST_DRAIN;
          w_cnt_nxt   = FENCE_INIT;
        end else if (w_accept && w_dec.illegal) begin
          w_state_nxt = ST_TRAP;
        end
      end
      ST_DRAIN: begin
        w_cnt_nxt = r_cnt - 8'd1;
        if (r_cnt <= 8'd1) begin
          w_state_nxt = ST_RUN;
          w_cnt_nxt   = 8'd0;
        end
      end
      ST_TRAP: w_state_nxt = ST_TRAP;
      default: w_state_nxt = ST_RUN;
    endcase
    if (flush) begin
      w_state_nxt = ST_RUN;
      w_cnt_nxt   = 8'd0;
    end
  end

  // Output register and skid entry steering.
  always_comb begin
    w_out_nxt        = r_out;
    w_out_valid_nxt  = r_out_valid;
    w_skid_nxt       = r_skid;
    w_skid_valid_nxt = r_skid_valid;
    if (!r_out_valid || out_ready) begin
      if (r_skid_valid) begin
        w_out_nxt        = r_skid;
        w_out_valid_nxt  = 1'b1;
        w_skid_valid_nxt = 1'b0;
      end else if (w_accept) begin
        w_out_nxt       = w_dec;
        w_out_valid_nxt = 1'b1;
      end else begin
        w_out_valid_nxt = 1'b0;
      end
    end else if (w_accept) begin
      w_skid_nxt       = w_dec;
      w_skid_valid_nxt = 1'b1;
    end
    if (flush) begin
      w_out_valid_nxt  = 1'b0;
      w_skid_valid_nxt = 1'b0;
    end
  end

  // State registers. in_ready is registered, so it is low in the reset
  // cycle and during the cycle right after reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state      <= ST_RUN;
      r_cnt        <= 8'd0;
      r_out        <= '0;
      r_out_valid  <= 1'b0;
      r_skid       <= '0;
      r_skid_valid <= 1'b0;
      r_in_ready   <= 1'b0;
    end else begin
      r_state      <= w_state_nxt;
      r_cnt        <= w_cnt_nxt;
      r_out        <= w_out_nxt;
      r_out_valid  <= w_out_valid_nxt;
      r_skid       <= w_skid_nxt;
      r_skid_valid <= w_skid_valid_nxt;
      r_in_ready   <= (w_state_nxt == ST_RUN) && !w_skid_valid_nxt;
    end
  end

  assign in_ready  = r_in_ready;
  assign out_valid = r_out_valid;
  assign out_inst  = r_out.inst;
  assign out_pc    = r_out.pc;
  assign immsel    = r_out.immsel;
  assign regwen    = r_out.regwen;
  assign asel      = r_out.asel;
  assign bsel      = r_out.bsel;
  assign alusel    = r_out.alusel;
  assign aluupper  = r_out.aluupper;
  assign memrw     = r_out.memrw;
  assign memword   = r_out.memword;
  assign memsign   = r_out.memsign;
  assign wbsel     = r_out.wbsel;
  assign jump      = r_out.jump;
  assign branch    = r_out.branch;
  assign brcond    = r_out.brcond;
  assign brun      = r_out.brun;
  assign illegal   = r_out.illegal;

endmodule

// File: tb/tb_cu_pipe.sv
// Bench for cu_pipe: one XLEN=64 and one XLEN=32 instance share stimulus.
module tb_cu_pipe;

  logic        clk = 1'b0;
  logic        rst, in_valid, flush, out_ready;
  logic [31:0] in_inst;
  logic [63:0] in_pc;

  logic        rdy64, ov64, rw64, as64, bs64, au64, mr64, ms64, jp64, br64, bu64, il64;
  logic [31:0] oi64;
  logic [63:0] op64;
  logic [2:0]  is64;
  logic [3:0]  al64;
  logic [1:0]  mw64, wb64, bc64;

  logic        rdy32, ov32, rw32, as32, bs32, au32, mr32, ms32, jp32, br32, bu32, il32;
  logic [31:0] oi32;
  logic [63:0] op32;
  logic [2:0]  is32;
  logic [3:0]  al32;
  logic [1:0]  mw32, wb32, bc32;

  logic [22:0] b64, b32;
  assign b64 = {is64, rw64, as64, bs64, al64, au64, mr64, mw64, ms64, wb64, jp64, br64, bc64, bu64, il64};
  assign b32 = {is32, rw32, as32, bs32, al32, au32, mr32, mw32, ms32, wb32, jp32, br32, bc32, bu32, il32};

  always #5 clk = ~clk;

  cu_pipe #(.XLEN(64), .FENCE_CYCLES(4), .PC_W(64)) dut64 (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(rdy64), .in_inst(in_inst),
    .in_pc(in_pc), .flush(flush), .out_valid(ov64), .out_ready(out_ready),
    .out_inst(oi64), .out_pc(op64), .immsel(is64), .regwen(rw64), .asel(as64),
    .bsel(bs64), .alusel(al64), .aluupper(au64), .memrw(mr64), .memword(mw64),
    .memsign(ms64), .wbsel(wb64), .jump(jp64), .branch(br64), .brcond(bc64),
    .brun(bu64), .illegal(il64));

  cu_pipe #(.XLEN(32), .FENCE_CYCLES(4), .PC_W(64)) dut32 (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(rdy32), .in_inst(in_inst),
    .in_pc(in_pc), .flush(flush), .out_valid(ov32), .out_ready(out_ready),
    .out_inst(oi32), .out_pc(op32), .immsel(is32), .regwen(rw32), .asel(as32),
    .bsel(bs32), .alusel(al32), .aluupper(au32), .memrw(mr32), .memword(mw32),
    .memsign(ms32), .wbsel(wb32), .jump(jp32), .branch(br32), .brcond(bc32),
    .brun(bu32), .illegal(il32));

  typedef struct {
    logic [31:0] inst;
    logic [2:0]  immsel;
    logic        regwen, asel, bsel;
    logic [3:0]  alusel;
    logic        aluupper, memrw;
    logic [1:0]  wbsel;
    logic        jump, branch, ill64, ill32;
  } vec_t;

  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    @(negedge clk);
  endtask

  // Expected bundle: illegal entries keep only the raw inst fields.
  function automatic logic [22:0] exp_pack(input vec_t v, input bit x32);
    logic        ill;
    logic [31:0] in;
    in  = v.inst;
    ill = x32 ? v.ill32 : v.ill64;
    if (ill)
      return {3'b0, 1'b0, 1'b0, 1'b0, 4'b0, 1'b0, 1'b0, in[13:12], in[14], 2'b0,
              1'b0, 1'b0, in[14], in[12], in[13], 1'b1};
    return {v.immsel, v.regwen, v.asel, v.bsel, v.alusel, v.aluupper, v.memrw,
            in[13:12], in[14], v.wbsel, v.jump, v.branch, in[14], in[12], in[13], 1'b0};
  endfunction

  vec_t vt[22];

  initial begin
    int n;
    //          inst          imm  rw   as   bs   alu      au   mr   wb    jp   br   i64  i32
    vt[0]  = '{32'h00500093, 3'd0, 1'b1, 1'b0, 1'b1, 4'b0000, 1'b1, 1'b0, 2'd0, 1'b0, 1'b0, 1'b0, 1'b0}; // addi
    vt[1]  = '{32'h40208133, 3'd0, 1'b1, 1'b0, 1'b0, 4'b1000, 1'b1, 1'b0, 2'd0, 1'b0, 1'b0, 1'b0, 1'b0}; // sub
    vt[2]  = '{32'h002081BB, 3'd0, 1'b1, 1'b0, 1'b0, 4'b0000, 1'b0, 1'b0, 2'd0, 1'b0, 1'b0, 1'b0, 1'b1}; // addw
    vt[3]  = '{32'h0000B083, 3'd0, 1'b1, 1'b0, 1'b1, 4'b0000, 1'b1, 1'b0, 2'd1, 1'b0, 1'b0, 1'b0, 1'b1}; // ld
    vt[4]  = '{32'h00000063, 3'd2, 1'b0, 1'b1, 1'b1, 4'b0000, 1'b1, 1'b0, 2'd0, 1'b0, 1'b1, 1'b0, 1'b0}; // beq
    vt[5]  = '{32'h00005063, 3'd2, 1'b0, 1'b1, 1'b1, 4'b0000, 1'b1, 1'b0, 2'd0, 1'b0, 1'b1, 1'b0, 1'b0}; // bge
    vt[6]  = '{32'h00002063, 3'd0, 1'b0, 1'b0, 1'b0, 4'b0000, 1'b0, 1'b0, 2'd0, 1'b0, 1'b0, 1'b1, 1'b1}; // branch f3=010
    vt[7]  = '{32'h00002023, 3'd1, 1'b0, 1'b0, 1'b1, 4'b0000, 1'b1, 1'b1, 2'd0, 1'b0, 1'b0, 1'b0, 1'b0}; // sw
    vt[8]  = '{32'h00003023, 3'd1, 1'b0, 1'b0, 1'b1, 4'b0000, 1'b1, 1'b1, 2'd0, 1'b0, 1'b0, 1'b0, 1'b1}; // sd
    vt[9]  = '{32'h40005013, 3'd0, 1'b1, 1'b0, 1'b1, 4'b1101, 1'b1, 1'b0, 2'd0, 1'b0, 1'b0, 1'b0, 1'b0}; // srai
    vt[10] = '{32'h40000013, 3'd0, 1'b1, 1'b0, 1'b1, 4'b0000, 1'b1, 1'b0, 2'd0, 1'b0, 1'b0, 1'b0, 1'b0}; // addi, bit30 set
    vt[11] = '{32'h000000B7, 3'd3, 1'b1, 1'b0, 1'b1, 4'b1111, 1'b1, 1'b0, 2'd0, 1'b0, 1'b0, 1'b0, 1'b0}; // lui
    vt[12] = '{32'h0000006F, 3'd4, 1'b1, 1'b1, 1'b1, 4'b0000, 1'b1, 1'b0, 2'd2, 1'b1, 1'b0, 1'b0, 1'b0}; // jal
    vt[13] = '{32'h00000010, 3'd0, 1'b0, 1'b0, 1'b0, 4'b0000, 1'b0, 1'b0, 2'd0, 1'b0, 1'b0, 1'b1, 1'b1}; // low bits 00
    vt[14] = '{32'h00000073, 3'd0, 1'b0, 1'b0, 1'b0, 4'b0000, 1'b0, 1'b0, 2'd0, 1'b0, 1'b0, 1'b1, 1'b1}; // ecall
    vt[15] = '{32'h00006003, 3'd0, 1'b1, 1'b0, 1'b1, 4'b0000, 1'b1, 1'b0, 2'd1, 1'b0, 1'b0, 1'b0, 1'b1}; // lwu
    vt[16] = '{32'h00007003, 3'd0, 1'b0, 1'b0, 1'b0, 4'b0000, 1'b0, 1'b0, 2'd0, 1'b0, 1'b0, 1'b1, 1'b1}; // load f3=111
    vt[17] = '{32'h00000067, 3'd0, 1'b1, 1'b0, 1'b1, 4'b0000, 1'b1, 1'b0, 2'd2, 1'b1, 1'b0, 1'b0, 1'b0}; // jalr
    vt[18] = '{32'h00000017, 3'd3, 1'b1, 1'b1, 1'b1, 4'b0000, 1'b1, 1'b0, 2'd0, 1'b0, 1'b0, 1'b0, 1'b0}; // auipc
    vt[19] = '{32'h0000000F, 3'd0, 1'b0, 1'b0, 1'b0, 4'b0000, 1'b0, 1'b0, 2'd0, 1'b0, 1'b0, 1'b0, 1'b0}; // fence nop
    vt[20] = '{32'h4000501B, 3'd0, 1'b1, 1'b0, 1'b1, 4'b1101, 1'b0, 1'b0, 2'd0, 1'b0, 1'b0, 1'b0, 1'b1}; // sraiw
    vt[21] = '{32'h00004023, 3'd0, 1'b0, 1'b0, 1'b0, 4'b0000, 1'b0, 1'b0, 2'd0, 1'b0, 1'b0, 1'b1, 1'b1}; // store f3=100

    rst = 1'b1; in_valid = 1'b0; flush = 1'b0; out_ready = 1'b1;
    in_inst = 32'h0; in_pc = 64'h0;
    @(negedge clk);
    tick();
    chk("reset out_valid", 64'(ov64), 64'd0);
    chk("reset in_ready", 64'(rdy64), 64'd0);
    chk("reset bundle", 64'(b64), 64'd0);
    chk("reset out_inst", 64'(oi64), 64'd0);
    rst = 1'b0;
    tick();
    chk("post-reset in_ready", 64'(rdy64), 64'd1);

    // Decode table on both XLEN variants.
    for (int i = 0; i < 22; i++) begin
      flush = 1'b1; in_valid = 1'b0;
      tick();
      flush = 1'b0;
      chk($sformatf("vec%0d ready64", i), 64'(rdy64), 64'd1);
      in_valid = 1'b1; in_inst = vt[i].inst; in_pc = 64'h1000 + 64'(i * 4);
      tick();
      in_valid = 1'b0;
      chk($sformatf("vec%0d valid64", i), 64'(ov64), 64'd1);
      chk($sformatf("vec%0d bundle64", i), 64'(b64), 64'(exp_pack(vt[i], 1'b0)));
      chk($sformatf("vec%0d bundle32", i), 64'(b32), 64'(exp_pack(vt[i], 1'b1)));
      chk($sformatf("vec%0d inst64", i), 64'(oi64), 64'(vt[i].inst));
      chk($sformatf("vec%0d pc64", i), op64, 64'h1000 + 64'(i * 4));
    end

    // Back-to-back stream with out_ready=1: no bubbles.
    flush = 1'b1; tick(); flush = 1'b0;
    in_valid = 1'b1; in_inst = 32'h00500093; in_pc = 64'h2000;
    tick();
    chk("stream addi valid", 64'(ov64), 64'd1);
    chk("stream addi inst", 64'(oi64), 64'h00500093);
    in_inst = 32'h40208133; in_pc = 64'h2004;
    tick();
    in_valid = 1'b0;
    chk("stream sub valid", 64'(ov64), 64'd1);
    chk("stream sub inst", 64'(oi64), 64'h40208133);
    chk("stream sub alusel", 64'(al64), 64'b1000);
    chk("stream sub aluupper", 64'(au64), 64'd1);
    tick();
    chk("stream drained", 64'(ov64), 64'd0);

    // Backpressure: output register, skid, then in-order drain.
    out_ready = 1'b0;
    in_valid = 1'b1; in_inst = 32'h00100093;
    tick();
    chk("bp ready after A", 64'(rdy64), 64'd1);
    in_inst = 32'h00200113;
    tick();
    chk("bp ready after B", 64'(rdy64), 64'd0);
    chk("bp out A", 64'(oi64), 64'h00100093);
    in_inst = 32'h00300193;
    tick();
    chk("bp hold A", 64'(oi64), 64'h00100093);
    chk("bp hold valid", 64'(ov64), 64'd1);
    out_ready = 1'b1;
    tick();
    chk("bp out B", 64'(oi64), 64'h00200113);
    chk("bp ready reopen", 64'(rdy64), 64'd1);
    tick();
    in_valid = 1'b0;
    chk("bp out C", 64'(oi64), 64'h00300193);
    chk("bp C valid", 64'(ov64), 64'd1);
    tick();
    chk("bp empty", 64'(ov64), 64'd0);

    // FENCE: nop bundle, then in_ready low for FENCE_CYCLES cycles.
    in_valid = 1'b1; in_inst = 32'h0000000F;
    tick();
    in_valid = 1'b0;
    chk("fence valid", 64'(ov64), 64'd1);
    chk("fence nop bundle", 64'(b64), 64'd0);
    n = 0;
    while (rdy64 == 1'b0 && n < 20) begin
      n++;
      tick();
    end
    chk("fence low cycles", 64'(n), 64'd4);

    // XLEN=32: addw traps, ld never accepted, flush recovers.
    flush = 1'b1; tick(); flush = 1'b0;
    in_valid = 1'b1; in_inst = 32'h002081BB;
    tick();
    chk("trap32 illegal", 64'(il32), 64'd1);
    chk("trap32 valid", 64'(ov32), 64'd1);
    chk("trap32 ready", 64'(rdy32), 64'd0);
    in_inst = 32'h0000B083;
    for (int k = 0; k < 3; k++) begin
      tick();
      chk($sformatf("trap32 ld blocked %0d", k), 64'({ov32, rdy32}), 64'd0);
    end
    in_valid = 1'b0; flush = 1'b1;
    tick();
    flush = 1'b0;
    chk("trap32 flush valid", 64'(ov32), 64'd0);
    chk("trap32 flush ready", 64'(rdy32), 64'd1);

    // Flush with a full skid, then flush against a same-cycle accept.
    out_ready = 1'b0;
    in_valid = 1'b1; in_inst = 32'h00100093;
    tick();
    in_inst = 32'h00200113;
    tick();
    chk("skid full ready", 64'(rdy64), 64'd0);
    in_inst = 32'h00300193; flush = 1'b1;
    tick();
    chk("flush full valid", 64'(ov64), 64'd0);
    chk("flush full ready", 64'(rdy64), 64'd1);
    tick();
    flush = 1'b0; in_valid = 1'b0;
    chk("flush accept dropped", 64'(ov64), 64'd0);
    out_ready = 1'b1;
    tick();
    chk("flush skid empty", 64'(ov64), 64'd0);

    // Reset in the middle of a FENCE drain.
    in_valid = 1'b1; in_inst = 32'h0000000F;
    tick();
    in_valid = 1'b0;
    tick();
    chk("drain ready low", 64'(rdy64), 64'd0);
    rst = 1'b1;
    tick();
    chk("rst drain ready", 64'(rdy64), 64'd0);
    chk("rst drain valid", 64'(ov64), 64'd0);
    rst = 1'b0;
    tick();
    chk("rst drain recover", 64'(rdy64), 64'd1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/cu_pipe.md
Name: cu_pipe

Overview:
Registered, handshaked successor to the combinational control unit, parametrised on XLEN.
- Accepts one instruction per cycle on a valid/ready input and decodes the same control bundle (immsel, regwen, asel, bsel, alusel, aluupper, memrw, memword, memsign, wbsel).
- Adds illegal-instruction detection, a FENCE drain counter, a trap hold and a flush.
- Branch outcome is no longer resolved here; the branch condition is forwarded to execute.
- Sits between fetch and execute as the decode pipeline register.

Parameters:
XLEN, 64, 32 or 64. With 32, OP-32, OP-IMM-32, LD, LWU and SD are illegal.
FENCE_CYCLES, 4, cycles in_ready is held low after a FENCE is accepted (1..255).
PC_W, 64, width of the pc side-band.

Ports:
clk  input  1  clock
rst  input  1  synchronous active-high reset
in_valid  input  1  instruction offered
in_ready  output  1  decoder can accept
in_inst  input  32  instruction word
in_pc  input  PC_W  pc of in_inst
flush  input  1  discard all held entries, leave trap/fence state
out_valid  output  1  bundle valid
out_ready  input  1  execute accepts bundle
out_inst  output  32  registered instruction
out_pc  output  PC_W  registered pc
immsel  output  3  `IMM_*` encoding from const.h
regwen  output  1  `REGW_EN`/`REGW_UN`
asel  output  1  `ASEL_*`
bsel  output  1  `BSEL_*`
alusel  output  4  ALU op
aluupper  output  1  1 = 64-bit op, 0 = 32-bit word op
memrw  output  1  `MEM_READ`/`MEM_WRITE`
memword  output  2  inst[13:12]
memsign  output  1  inst[14]
wbsel  output  2  `WB_*`
jump  output  1  JAL/JALR
branch  output  1  conditional branch
brcond  output  2  {inst[14],inst[12]} (`BRAN_*`)
brun  output  1  inst[13]
illegal  output  1  trap request

Behaviour:
Reset:
- out_valid=0, all bundle fields 0 (regwen=`REGW_UN`, memrw=`MEM_READ`).
- Skid entry empty, state RUN, drain counter 0, in_ready=0 in the reset cycle.

Storage:
- Output register plus one skid entry.
- in_ready = (state==RUN) && !skid_valid, driven from registers only.
- Accept = in_valid && in_ready.
- Accepted instruction goes to the output register if it is empty or being consumed (out_ready) this cycle. Otherwise it goes to the skid entry.
- Skid drains into the output register on the first cycle out_ready && out_valid.

Latency:
- Accept at cycle N gives out_valid at N+1.
- Sustained throughput is 1 per cycle while out_ready=1.

Output hold:
- While out_valid && !out_ready, every output holds stable.

Decode:
- Per opcode inst[6:2], identical to the existing cu field assignments.
- OP-IMM and OP-IMM-32: alusel = funct3==101 ? {inst[30],funct3} : {0,funct3}.
- OP and OP-32: alusel = {inst[30],funct3}.
- aluupper=0 only for OP-32 and OP-IMM-32.
- JAL/JALR: jump=1. BRANCH: branch=1.

Illegal (illegal=1, regwen=`REGW_UN`, memrw=`MEM_READ`, jump=branch=0):
- inst[1:0]!=2'b11.
- Unlisted opcode, or OP_PRIV.
- BRANCH with funct3 010 or 011.
- LOAD with funct3 111; also 011 or 110 when XLEN=32.
- STORE with funct3[2]=1; also 011 when XLEN=32.
- OP-32 or OP-IMM-32 when XLEN=32.

State machine:
- RUN:
  - Accepting FENCE emits a nop bundle (regwen=UN, memrw=READ) and goes to DRAIN with counter=FENCE_CYCLES.
  - Accepting an illegal instruction emits the bundle with illegal=1 and goes to TRAP.
- DRAIN: in_ready=0. Counter decrements each cycle. At counter==1 the next state is RUN.
- TRAP: in_ready=0 until flush.

Flush:
- Clears out_valid and the skid entry, forces RUN and zeroes the counter.
- Wins over a same-cycle accept; that instruction is dropped, in_ready having been 1.
- Wins over same-cycle out_ready; the consumer treats flush as discarding.

Simultaneous events:
- Accept and consume in the same cycle with the skid empty: the output register reloads and no bubble appears.

Reset mid-operation:
- Returns to the reset state above regardless of state or counter.

Test Plan:
1. XLEN=64. Stream addi x1,x0,5 (0x00500093), then sub (0x40208133), with out_ready=1. -> out_valid from cycle 2; the addi bundle has alusel=0000 and bsel=IMM; the sub bundle has alusel=1000 and aluupper=1. No bubbles.
2. Issue 3 instructions back-to-back with out_ready=0 for 3 cycles. -> First in the output register, second in skid, in_ready=0 after the second. On out_ready=1 they emerge in order, one per cycle, with no loss.
3. FENCE (0x0000000F) with FENCE_CYCLES=4. -> Nop bundle emitted; in_ready low for exactly 4 cycles after accept, then high.
4. XLEN=32. addw (0x002081BB), then ld (0x0000B083). -> addw emitted with illegal=1 and state TRAP; ld never accepted. Pulse flush -> out_valid=0 and in_ready=1 next cycle.
5. beq with in_inst[14:12]=000, then bge with 101. -> branch=1 on both; brcond 00/11; brun 0/0; jump=0.
6. Pulse flush in the same cycle as an accept while the skid is full. -> Both entries and the new instruction discarded; out_valid=0 next cycle. Assert rst mid-DRAIN -> in_ready=1 two cycles later.
